// File: rtl/csam_seq_mul_pkg.sv
// Shared types and constants for the sequential CSAM multiplier.
// Holds the FSM encoding and the fixed widths of the 8x11 array core.
package csam_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CSAM_XW = 8;
    localparam int CSAM_YW = 11;
    localparam int CSAM_ZW = 19;

endpackage

// File: rtl/csam_seq_mul_if.sv
// Operand/result bus of the sequential multiplier.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds
// valid and data stable until that edge, and ready never depends combinationally on valid.
interface csam_seq_mul_if #(
    parameter int XW = 16
);
    localparam int ZW = XW + 11;

    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] x;
    logic [10:0]   y;
    logic          out_valid;
    logic          out_ready;
    logic [ZW-1:0] z;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, z
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, z
    );

endinterface

// File: rtl/csam_seq_mul_csam.sv
// CSAM: combinational 8x11 unsigned carry-save array multiplier.
// Each row is a vector of full adders; a final ripple adder merges sum and carry.
module CSAM (
    input  logic [7:0]  X,
    input  logic [10:0] Y,
    output logic [18:0] Z
);

    always_comb begin
        logic [10:0] s;
        logic [10:0] c;
        logic [10:0] sh;
        logic [10:0] pp;
        Z  = '0;
        s  = Y & {11{X[0]}};
        c  = '0;
        sh = '0;
        pp = '0;
        Z[0] = s[0];
        // s[j] weighs i+j and c[j] weighs i+j+1 after row i
        for (int i = 1; i < 8; i++) begin
            pp   = Y & {11{X[i]}};
            sh   = s >> 1;
            s    = pp ^ sh ^ c;
            c    = (pp & sh) | (pp & c) | (sh & c);
            Z[i] = s[0];
        end
        Z[18:8] = (s >> 1) + c;
    end

endmodule

// File: rtl/csam_seq_mul.sv
// Sequential XW x 11 multiplier: feeds one 8-bit slice of X per cycle into CSAM
// and accumulates the shifted 19-bit partial products into the full product.
module csam_seq_mul
    import csam_seq_pkg::*;
#(
    parameter int XW = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    csam_seq_mul_if.slave  bus,
    output logic           busy,
    output state_e         dbg_state
);

    localparam int NCH = XW / 8;
    localparam int ZW  = XW + 11;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [ZW-1:0]          acc_q, acc_d;
    logic [XW-1:0]          x_q, x_d;
    logic [CSAM_YW-1:0]     y_q, y_d;
    logic [CSAM_XW-1:0]     csam_x;
    logic [CSAM_ZW-1:0]     csam_z;

    assign csam_x = x_q[{k_q, 3'b000} +: CSAM_XW];

    CSAM u_csam (
        .X (csam_x),
        .Y (y_q),
        .Z (csam_z)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = MUL;
            MUL:     if (k_q == K_LAST) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands and acc only move in IDLE (capture) and MUL (accumulate), so DONE holds them.
    always_comb begin
        k_d   = k_q;
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d   = bus.x;
                    y_d   = bus.y;
                    acc_d = '0;
                    k_d   = '0;
                end
            end
            MUL: begin
                acc_d = acc_q + (ZW'(csam_z) << {k_q, 3'b000});
                if (k_q != K_LAST) k_d = k_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        busy          = (state_q != IDLE);
        dbg_state     = state_q;
    end

    assign bus.z = acc_q;

endmodule

// File: tb/tb_csam_seq_mul.sv
// Directed bench for csam_seq_mul: driver tasks push hand-computed products into a
// queue; a negedge monitor pops and compares on every out_valid && out_ready.
module tb_csam_seq_mul;
  import csam_seq_pkg::*;

  localparam int XW  = 16;
  localparam int NCH = XW / 8;
  localparam int ZW  = XW + 11;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  logic   busy;
  state_e dbg_state;

  csam_seq_mul_if #(.XW(XW)) bus();

  csam_seq_mul #(.XW(XW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [ZW-1:0] exp_q[$];
  logic fire_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      fire_prev = 1'b0;
    end else begin
      if (fire_prev) check("ov_single_pulse", {63'd0, bus.out_valid}, 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else check("z", {{(64-ZW){1'b0}}, bus.z}, {{(64-ZW){1'b0}}, exp_q.pop_front()});
        fire_prev = 1'b1;
      end else begin
        fire_prev = 1'b0;
      end
    end
  end

  // driver: present an operand pair, push the expected product on acceptance
  task automatic send(input logic [XW-1:0] xv, input logic [10:0] yv, input logic [ZW-1:0] zv);
    bit ok;
    ok = 1'b0;
    bus.x = xv;
    bus.y = yv;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(zv);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // edges from the accept edge (inclusive) to the edge that raises out_valid
  task automatic wait_ov(output int n);
    n = 1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int acc_c[3];
    int idx;
    logic [XW-1:0] xs[3];
    logic [10:0]   ys[3];
    logic [ZW-1:0] zs[3];

    xs = '{16'd2, 16'd4, 16'd65535};
    ys = '{11'd3, 11'd5, 11'd1};
    zs = '{27'd6, 27'd20, 27'd65535};

    // 1: reset with in_valid asserted
    bus.in_valid  = 1'b1;
    bus.x         = 16'h0055;
    bus.y         = 11'h003;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_z", {{(64-ZW){1'b0}}, bus.z}, 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", {63'd0, busy}, 64'd0);
      check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    end
    @(posedge clk);
    #1;

    // 2: max operands, latency, single pulse
    bus.out_ready = 1'b1;
    send(16'hFFFF, 11'h7FF, 27'h7FEF801);
    wait_ov(n);
    check("latency", 64'(n), 64'(NCH + 1));
    wait_drain();

    // 3: back-pressure with an ignored second request
    bus.out_ready = 1'b0;
    send(16'h1234, 11'h005, 27'h0005B04);
    wait_ov(n);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.x = 16'h0001;
    bus.y = 11'h005;
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold_z", {{(64-ZW){1'b0}}, bus.z}, 64'h5B04);
      check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("hold_state", 64'(dbg_state), 64'(DONE));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();
    repeat (2) begin
      @(negedge clk);
      check("after_done_busy", {63'd0, busy}, 64'd0);
      check("after_done_in_ready", {63'd0, bus.in_ready}, 64'd1);
    end
    @(posedge clk);
    #1;

    // 4: zero low slice, zero high slice
    send(16'h0100, 11'h400, 27'h0040000);
    wait_drain();
    send(16'h00FF, 11'h001, 27'h00000FF);
    wait_drain();

    // 5: reset during the k=1 MUL cycle discards the operation
    send(16'hABCD, 11'h3FF, 27'(43981 * 1023));
    @(posedge clk);
    #1;
    check("abort_state_mul", 64'(dbg_state), 64'(MUL));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_z", {{(64-ZW){1'b0}}, bus.z}, 64'd0);
    repeat (4) begin
      check("abort_no_ov", {63'd0, bus.out_valid}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(16'd3, 11'd7, 27'd21);
    wait_drain();

    // 6: streaming with in_valid and out_ready held high
    idx = 0;
    bus.x = xs[0];
    bus.y = ys[0];
    bus.in_valid = 1'b1;
    for (int t = 0; t < 60 && idx < 3; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(zs[idx]);
        acc_c[idx] = cyc + 1;
        idx++;
        @(posedge clk);
        #1;
        if (idx < 3) begin
          bus.x = xs[idx];
          bus.y = ys[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("stream_accepts", 64'(idx), 64'd3);
    if (idx == 3) begin
      check("stream_gap_01", 64'(acc_c[1] - acc_c[0]), 64'(NCH + 2));
      check("stream_gap_12", 64'(acc_c[2] - acc_c[1]), 64'(NCH + 2));
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // final report
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
